// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a table of saturating counters,
// indexed bimodally or gshare-style, trained at resolve, with resolve/mispredict statistics.
module branch_predictor #(
  parameter int IDX_BITS  = 6,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 6,
  parameter int GSHARE    = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [31:0]          PC_current,
  output logic [31:0]          PCPredict,
  output logic                 prediction,
  output logic                 btb_hit,
  input  logic [31:0]          PC,
  input  logic [31:0]          PCBranch,
  input  logic                 Branch,
  input  logic                 BranchTaken,
  input  logic                 PredictedE,
  output logic [HIST_BITS-1:0] ghr,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  typedef logic [IDX_BITS-1:0] idx_t;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q [ENTRIES];
  logic [31:0]          tgt_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]          bcnt_q, mcnt_q;

  idx_t              f_idx, u_idx, u_pidx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic [CTR_BITS-1:0] f_ctr, u_ctr, ctr_d;

  function automatic idx_t pat_idx(input idx_t b, input logic [HIST_BITS-1:0] h);
    return (GSHARE != 0) ? (b ^ idx_t'(h)) : b;
  endfunction

  // Lookup reads registered state only, so a same-cycle update is seen one cycle later.
  assign f_idx      = PC_current[IDX_BITS+1:2];
  assign f_tag      = PC_current[31:IDX_BITS+2];
  assign btb_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_ctr      = ctr_q[pat_idx(f_idx, ghr_q)];
  assign prediction = btb_hit && f_ctr[CTR_BITS-1];
  assign PCPredict  = prediction ? tgt_q[f_idx] : PC_current + 32'd4;

  assign u_idx  = PC[IDX_BITS+1:2];
  assign u_tag  = PC[31:IDX_BITS+2];
  assign u_pidx = pat_idx(u_idx, ghr_q);
  assign u_ctr  = ctr_q[u_pidx];

  always_comb begin
    ctr_d = u_ctr;
    if (BranchTaken && u_ctr != CTR_MAX)        ctr_d = u_ctr + CTR_BITS'(1);
    else if (!BranchTaken && u_ctr != '0)       ctr_d = u_ctr - CTR_BITS'(1);
  end

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_d = BranchTaken;
    end else begin : g_histn
      assign ghr_d = {ghr_q[HIST_BITS-2:0], BranchTaken};
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_INIT;
    end else if (Branch) begin
      ctr_q[u_pidx] <= ctr_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                          valid_q        <= '0;
    else if (Branch && BranchTaken)   valid_q[u_idx] <= 1'b1;
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (Branch && BranchTaken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= PCBranch;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ghr_q  <= '0;
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else if (Branch) begin
      ghr_q <= ghr_d;
      if (bcnt_q != '1) bcnt_q <= bcnt_q + 32'd1;
      if (BranchTaken != PredictedE && mcnt_q != '1) mcnt_q <= mcnt_q + 32'd1;
    end
  end

  assign ghr              = ghr_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench: a bimodal and a gshare (2-bit history) predictor share one stimulus stream and are
// compared every cycle against an array-based model, plus directed literal checks.
module tb_branch_predictor;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] PC_current, PC, PCBranch;
  logic        Branch, BranchTaken, PredictedE;

  logic        pred_w [2];
  logic        hit_w  [2];
  logic [31:0] ppc_w  [2];
  logic [31:0] bc_w   [2];
  logic [31:0] mc_w   [2];
  logic [5:0]  ghr0;
  logic [1:0]  ghr1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 Clk = ~Clk;

  branch_predictor #(.IDX_BITS(6), .CTR_BITS(2), .HIST_BITS(6), .GSHARE(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .PC_current(PC_current), .PCPredict(ppc_w[0]),
    .prediction(pred_w[0]), .btb_hit(hit_w[0]), .PC(PC), .PCBranch(PCBranch),
    .Branch(Branch), .BranchTaken(BranchTaken), .PredictedE(PredictedE),
    .ghr(ghr0), .branch_count(bc_w[0]), .mispredict_count(mc_w[0]));

  branch_predictor #(.IDX_BITS(6), .CTR_BITS(2), .HIST_BITS(2), .GSHARE(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .PC_current(PC_current), .PCPredict(ppc_w[1]),
    .prediction(pred_w[1]), .btb_hit(hit_w[1]), .PC(PC), .PCBranch(PCBranch),
    .Branch(Branch), .BranchTaken(BranchTaken), .PredictedE(PredictedE),
    .ghr(ghr1), .branch_count(bc_w[1]), .mispredict_count(mc_w[1]));

  // Reference model: plain arrays, 64 entries, tag = pc >> 8, counters 0..3.
  int          hb [2] = '{6, 2};
  bit          gs [2] = '{1'b0, 1'b1};
  bit          m_val [2][64];
  int unsigned m_tag [2][64];
  int unsigned m_tgt [2][64];
  int unsigned m_ctr [2][64];
  int unsigned m_ghr [2];
  int unsigned m_bc  [2];
  int unsigned m_mc  [2];

  function automatic int unsigned bidx(input int unsigned pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic int unsigned pidx(input int k, input int unsigned pc);
    return gs[k] ? (bidx(pc) ^ m_ghr[k]) : bidx(pc);
  endfunction

  function automatic bit m_hit(input int k, input int unsigned pc);
    return m_val[k][bidx(pc)] && m_tag[k][bidx(pc)] == (pc >> 8);
  endfunction

  function automatic bit m_pred(input int k, input int unsigned pc);
    return m_hit(k, pc) && m_ctr[k][pidx(k, pc)] >= 2;
  endfunction

  function automatic int unsigned m_ppc(input int k, input int unsigned pc);
    return m_pred(k, pc) ? m_tgt[k][bidx(pc)] : pc + 4;
  endfunction

  task automatic model_step();
    if (Rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 64; i++) begin
          m_val[k][i] = 1'b0;
          m_ctr[k][i] = 1;
        end
        m_ghr[k] = 0; m_bc[k] = 0; m_mc[k] = 0;
      end
    end else if (Branch) begin
      for (int k = 0; k < 2; k++) begin
        int unsigned p;
        p = pidx(k, PC);
        if (BranchTaken) begin
          if (m_ctr[k][p] < 3) m_ctr[k][p]++;
          m_val[k][bidx(PC)] = 1'b1;
          m_tag[k][bidx(PC)] = PC >> 8;
          m_tgt[k][bidx(PC)] = PCBranch;
        end else if (m_ctr[k][p] > 0) begin
          m_ctr[k][p]--;
        end
        m_ghr[k] = ((m_ghr[k] << 1) | int'(BranchTaken)) % (1 << hb[k]);
        if (m_bc[k] != 32'hFFFFFFFF) m_bc[k]++;
        if (BranchTaken != PredictedE && m_mc[k] != 32'hFFFFFFFF) m_mc[k]++;
      end
    end
  endtask

  always @(posedge Clk or posedge Rst) model_step();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en && !Rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("hit%0d", k),  32'(hit_w[k]),  32'(m_hit(k, PC_current)));
        chk($sformatf("pred%0d", k), 32'(pred_w[k]), 32'(m_pred(k, PC_current)));
        chk($sformatf("ppc%0d", k),  ppc_w[k],       m_ppc(k, PC_current));
        chk($sformatf("bc%0d", k),   bc_w[k],        m_bc[k]);
        chk($sformatf("mc%0d", k),   mc_w[k],        m_mc[k]);
      end
      chk("ghr0", 32'(ghr0), m_ghr[0]);
      chk("ghr1", 32'(ghr1), m_ghr[1]);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit t, input bit pe);
    Branch = 1'b1; PC = pc; PCBranch = tgt; BranchTaken = t; PredictedE = pe;
    step();
    Branch = 1'b0;
  endtask

  function automatic logic [31:0] pool_pc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'h00400000 | ((r % 4) << 2) | (((r >> 2) & 1) << 8);
    if (r == 8) return 32'hFFFFFFFC;
    return $urandom & 32'hFFFFFFFC;
  endfunction

  initial begin
    Rst = 1'b1; Branch = 1'b0; BranchTaken = 1'b0; PredictedE = 1'b0;
    PC = '0; PCBranch = '0; PC_current = 32'h00400010;
    #12 Rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_hit", 32'(hit_w[0]), 32'd0);
    chk("rst_pred", 32'(pred_w[0]), 32'd0);
    chk("rst_ppc", ppc_w[0], 32'h00400014);
    chk("rst_ghr", 32'(ghr0), 32'd0);
    chk("rst_bc", bc_w[0], 32'd0);
    chk("rst_mc", mc_w[0], 32'd0);
    step();

    // Bimodal training on one PC
    upd(32'h00400010, 32'h00400100, 1'b1, 1'b0);
    chk("t1_hit", 32'(hit_w[0]), 32'd1);
    chk("t1_pred", 32'(pred_w[0]), 32'd1);
    chk("t1_ppc", ppc_w[0], 32'h00400100);
    chk("t1_mc", mc_w[0], 32'd1);
    upd(32'h00400010, 32'h0, 1'b0, 1'b0);
    upd(32'h00400010, 32'h0, 1'b0, 1'b0);
    chk("n2_pred", 32'(pred_w[0]), 32'd0);
    chk("n2_ppc", ppc_w[0], 32'h00400014);
    chk("n2_hit", 32'(hit_w[0]), 32'd1);
    upd(32'h00400010, 32'h0, 1'b0, 1'b0);
    chk("n3_bc", bc_w[0], 32'd4);
    upd(32'h00400010, 32'h00400100, 1'b1, 1'b0);
    chk("sat0_pred", 32'(pred_w[0]), 32'd0);

    // Same-cycle collision: counter at 1, taken update while looking up the same PC
    Branch = 1'b1; PC = 32'h00400010; PCBranch = 32'h00400100; BranchTaken = 1'b1; PredictedE = 1'b0;
    #2 chk("col_now", 32'(pred_w[0]), 32'd0);
    step();
    Branch = 1'b0;
    #1 chk("col_next", 32'(pred_w[0]), 32'd1);
    chk("col_bc", bc_w[0], 32'd6);
    chk("col_mc", mc_w[0], 32'd3);

    // Alias: same index, different tag
    PC_current = 32'h00400110;
    #1 chk("alias_hit", 32'(hit_w[0]), 32'd0);
    chk("alias_ppc", ppc_w[0], 32'h00400114);
    step();
    upd(32'h00400110, 32'h00400200, 1'b1, 1'b0);
    PC_current = 32'h00400010;
    #1 chk("repl_old_hit", 32'(hit_w[0]), 32'd0);
    chk("repl_old_ppc", ppc_w[0], 32'h00400014);
    PC_current = 32'h00400110;
    #1 chk("repl_new_ppc", ppc_w[0], 32'h00400200);
    step();

    // Gshare learns an alternating pattern
    PC_current = 32'h00400040;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        bit t;
        t = (j == 0);
        #1 PredictedE = pred_w[1];
        if (i >= 4) chk($sformatf("gs_pred_%0d_%0d", i, j), 32'(pred_w[1]), 32'(t));
        Branch = 1'b1; PC = 32'h00400040; PCBranch = 32'h00400800; BranchTaken = t;
        step();
        Branch = 1'b0;
      end
    end
    chk("gs_ghr", 32'(ghr1), 32'h2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      PC = pool_pc();
      PC_current = ($urandom_range(0, 1) == 0) ? PC : pool_pc();
      PCBranch = $urandom & 32'hFFFFFFFC;
      Branch = ($urandom_range(0, 9) < 6);
      BranchTaken = $urandom_range(0, 1);
      PredictedE = $urandom_range(0, 1);
      step();
    end
    Branch = 1'b0;

    // Asynchronous reset mid-cycle
    PC_current = 32'h00400010;
    #2 Rst = 1'b1;
    #1;
    chk("arst_hit", 32'(hit_w[0]), 32'd0);
    chk("arst_pred", 32'(pred_w[0]), 32'd0);
    chk("arst_ppc", ppc_w[0], 32'h00400014);
    chk("arst_ghr", 32'(ghr0), 32'd0);
    chk("arst_bc", bc_w[0], 32'd0);
    chk("arst_mc", mc_w[0], 32'd0);
    chk("arst_pred1", 32'(pred_w[1]), 32'd0);
    step();
    Rst = 1'b0;
    step();

    // Statistics saturation
    force dut0.bcnt_q = 32'hFFFFFFFE;
    #1 release dut0.bcnt_q;
    m_bc[0] = 32'hFFFFFFFE;
    upd(32'h00400020, 32'h00400300, 1'b1, 1'b1);
    chk("sat_bc1", bc_w[0], 32'hFFFFFFFF);
    upd(32'h00400020, 32'h00400300, 1'b1, 1'b1);
    upd(32'h00400020, 32'h00400300, 1'b0, 1'b1);
    chk("sat_bc3", bc_w[0], 32'hFFFFFFFF);
    step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the fetch-stage branch target buffer and branch history table: one block holding a direct-mapped BTB and a pattern table of saturating counters.
- Selectable bimodal or gshare indexing, plus resolved-branch and mispredict statistics counters.
- Looks up the fetch PC combinationally and is trained from the execute stage with the resolved branch outcome.

Parameters:
- IDX_BITS, 6, log2 of BTB and pattern-table entries (index = PC[IDX_BITS+1:2]).
- CTR_BITS, 2, width of each saturating counter (>=1).
- HIST_BITS, 6, global history register width; must be <= IDX_BITS.
- GSHARE, 0, 0 = bimodal index, 1 = PC index XOR history (history zero-extended to IDX_BITS).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- PC_current  in  32  fetch-stage PC.
- PCPredict  out  32  next fetch PC: target if predicted taken, else PC_current+4.
- prediction  out  1  predicted taken for PC_current.
- btb_hit  out  1  valid BTB entry with matching tag for PC_current.
- PC  in  32  PC of branch in execute.
- PCBranch  in  32  resolved branch target.
- Branch  in  1  execute-stage instruction is a conditional branch (update strobe).
- BranchTaken  in  1  resolved outcome.
- PredictedE  in  1  prediction carried down the pipe with that branch.
- ghr  out  HIST_BITS  current global history.
- branch_count  out  32  resolved branches since reset.
- mispredict_count  out  32  mispredictions since reset.

Behaviour:
- Tag = PC[31:IDX_BITS+2]. BTB index = PC[IDX_BITS+1:2]. Pattern index = BTB index in bimodal mode; BTB index XOR ghr in gshare mode.
- Lookup is purely combinational from PC_current and the current register state, with no bypass.
  - btb_hit = valid[i] && tag[i]==PC_current tag.
  - prediction = btb_hit && counter MSB.
  - PCPredict = prediction ? target[i] : PC_current+4, where the adder wraps modulo 2^32.
- Update happens on the rising Clk edge when Branch=1. Nothing changes when Branch=0.
  - Counter at the pattern index computed from PC and the pre-update ghr: increment if taken, saturating at 2^CTR_BITS-1; decrement if not taken, saturating at 0.
  - BTB: if taken, write valid=1, tag and PCBranch at the BTB index, replacing any existing entry. If not taken, the BTB entry is left unchanged (allocate on taken only).
  - ghr <= {ghr[HIST_BITS-2:0], BranchTaken}. The history is non-speculative and updated only at resolve.
  - branch_count increments by 1, saturating at 32'hFFFFFFFF.
  - mispredict_count increments by 1 when BranchTaken != PredictedE, saturating the same way.
- Lookup and update to the same entry in the same cycle: the lookup returns the pre-update value, and the update is visible from the next cycle.
- Reset (asynchronous, any time, including mid-update):
  - all valid bits = 0;
  - all counters = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2-bit, 0 for 1-bit);
  - ghr = 0;
  - both statistics counters = 0.
  - Outputs therefore settle to prediction=0, btb_hit=0, PCPredict=PC_current+4.
  - Tags and targets need not be reset.
- The table is storage arrays of 2^IDX_BITS entries. No handshake: update is single-cycle and the block never stalls the pipeline.

Test Plan:
- Reset, then PC_current=0x00400010 -> btb_hit=0, prediction=0, PCPredict=0x00400014, ghr=0, both counters 0.
- Bimodal, 2-bit counters: one taken update with PC=0x00400010, PCBranch=0x00400100, PredictedE=0.
  - Next cycle, lookup of 0x00400010 -> btb_hit=1, counter=2, prediction=1, PCPredict=0x00400100, mispredict_count=1.
  - Two not-taken updates -> counter 0, prediction=0. A third not-taken update -> counter stays 0. branch_count=4.
- Alias: entry trained taken at 0x00400010, then lookup 0x00400110 (same index, different tag) -> btb_hit=0, PCPredict=0x00400114.
  - A taken update for 0x00400110 replaces the entry, so a lookup of 0x00400010 now misses.
- Same-cycle collision: with the counter at 1 and the BTB valid, assert a taken update while PC_current equals the same PC.
  - In that cycle -> prediction=0. Next cycle -> prediction=1.
- GSHARE=1, HIST_BITS=2: train the pattern T,N,T,N repeatedly on PC 0x00400040 -> after warm-up (ghr alternating 01/10), prediction matches every outcome and mispredict_count stops incrementing. ghr after the sequence T,N = 2'b10.
- Assert Rst mid-stream with counters at 0x0000000A/0x00000003 -> all outputs return immediately to their reset values, without waiting for a Clk edge.
- Saturation: preload branch_count near its maximum (force or long run) -> it holds at 0xFFFFFFFF and does not wrap.
